// File: rtl/mux_rr_nx1.sv
// N-to-1 valid/ready multiplexer with manual or round-robin channel selection
// and a single registered output stage.
module mux_rr_nx1 #(
    parameter int N = 8,
    parameter int W = 8,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [SW-1:0]  out_chan
);

    logic [SW-1:0] ptr;
    logic          load_ok;
    logic          grant;
    logic [SW-1:0] gnt_idx;
    logic [W-1:0]  gnt_data;
    logic [SW-1:0] ptr_next;

    assign load_ok = !out_valid || out_ready;

    // Grant decision: manual index or first valid channel at/after ptr, wrapping.
    // Round-robin search is split into two passes (channels >= ptr, then any)
    // so that every index into in_valid/in_data is a loop constant.
    always_comb begin
        grant    = 1'b0;
        gnt_idx  = '0;
        gnt_data = '0;
        if (!rst && load_ok) begin
            if (!mode) begin
                // sel >= N never matches any loop index, so it yields no grant
                for (int unsigned i = 0; i < N; i++) begin
                    if (SW'(i) == sel && in_valid[i]) begin
                        grant    = 1'b1;
                        gnt_idx  = SW'(i);
                        gnt_data = in_data[i*W +: W];
                    end
                end
            end else begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (!grant && SW'(i) >= ptr && in_valid[i]) begin
                        grant    = 1'b1;
                        gnt_idx  = SW'(i);
                        gnt_data = in_data[i*W +: W];
                    end
                end
                for (int unsigned i = 0; i < N; i++) begin
                    if (!grant && in_valid[i]) begin
                        grant    = 1'b1;
                        gnt_idx  = SW'(i);
                        gnt_data = in_data[i*W +: W];
                    end
                end
            end
        end
    end

    // One-hot ready toward the granted channel only.
    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            in_ready[i] = grant && (gnt_idx == SW'(i));
        end
    end

    // Pointer advances to the channel after the winner, wrapping N-1 -> 0.
    always_comb begin
        ptr_next = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + SW'(1);
    end

    // Output register stage and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= '0;
        end else begin
            if (grant) begin
                out_valid <= 1'b1;
                out_data  <= gnt_data;
                out_chan  <= gnt_idx;
                if (mode) begin
                    ptr <= ptr_next;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mux_rr_nx1.md
MUX_RR_NX1 -- requirements
Module: mux_rr_nx1

Interface
REQ-001 Parameter N, default 8, number of input channels (2..32).
REQ-002 Parameter W, default 8, data width per channel (1..64).
REQ-003 Derived constant SW = clog2(N), the channel-index width; it is not overridable.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_data  input  N*W  packed channel data; channel i occupies bits [i*W +: W].
REQ-007 in_valid  input  N  per-channel valid.
REQ-008 in_ready  output  N  per-channel ready, combinational; at most one bit is high per cycle.
REQ-009 mode  input  1  selects arbitration: 0 = manual select, 1 = round-robin.
REQ-010 sel  input  SW  channel index, used only when mode=0.
REQ-011 out_data  output  W  registered output data.
REQ-012 out_valid  output  1  registered output valid.
REQ-013 out_ready  input  1  downstream ready.
REQ-014 out_chan  output  SW  registered index of the channel that supplied out_data.

Function
REQ-015 Transfers shall use valid/ready: an input beat transfers when in_valid[i] & in_ready[i]; an output beat transfers when out_valid & out_ready.
REQ-016 A single output register stage shall be used; it can load when !out_valid | out_ready ("load_ok").
REQ-017 Manual mode (mode=0): grant shall go to channel sel when in_valid[sel] & load_ok & sel<N; otherwise there is no grant.
REQ-018 Round-robin mode (mode=1): grant shall go to the first channel with in_valid high, searching from pointer ptr upward and wrapping from N-1 to 0, only when load_ok.
REQ-019 in_ready[g] shall be 1 only for the granted channel g, and 0 for all channels when there is no grant.
REQ-020 On a grant, the next edge shall set out_data=in_data[g], out_chan=g, out_valid=1.
REQ-021 Latency shall be 1 cycle from input transfer to out_valid.
REQ-022 Full throughput shall be sustained: one beat per cycle while out_ready=1.
REQ-023 When out_valid & out_ready and there is no grant, the next edge shall set out_valid=0; out_data and out_chan hold.
REQ-024 While out_valid & !out_ready (backpressure), out_data, out_valid and out_chan shall hold stable and in_ready shall be all 0.
REQ-025 ptr (SW bits) shall update to (g+1) mod N on every round-robin grant, wrapping N-1 -> 0, and shall hold otherwise.
REQ-026 In manual mode ptr shall hold and is not modified by grants.
REQ-027 A change of mode or sel shall take effect on the same cycle's grant decision and shall never alter an already-registered output beat.
REQ-028 Round-robin shall be starvation-free: a continuously valid channel is granted within N grants.
REQ-029 Every channel valid simultaneously in round-robin shall give grant order ptr, ptr+1, ... mod N.
REQ-030 sel >= N (possible when N is not a power of 2) shall give no grant, with in_ready all 0.

Reset
REQ-031 While rst=1 at a clock edge: out_valid=0, out_data=0, out_chan=0, ptr=0.
REQ-032 While rst=1, in_ready shall be all 0.
REQ-033 A beat held in the output register is discarded by reset, with no partial transfer.
REQ-034 In the first cycle after rst deasserts, arbitration shall start from ptr=0.

Verification
REQ-035 Reset, then mode=0, sel=3, in_valid=8'h08, data ch3=8'hA5, out_ready=1 -> in_ready=8'h08 that cycle; next cycle out_valid=1, out_data=8'hA5, out_chan=3.
REQ-036 mode=1, in_valid=8'hFF held, out_ready=1 for 10 cycles -> out_chan sequence 0,1,2,...,7,0,1 with no gaps.
REQ-037 mode=1, in_valid=8'h81, ptr=1 -> grant 7, then 0, then 7 (wrap 7 -> 0 verified); ptr values 0, 1, 0 after the grants.
REQ-038 Output loaded, then out_ready=0 for 4 cycles with in_valid=8'hFF -> out_data/out_chan stable and in_ready=0 each cycle; out_ready=1 -> transfer plus new grant in the same cycle.
REQ-039 N=6: mode=0, sel=7 -> in_ready=0 and out_valid stays 0.
REQ-040 rst pulsed for 1 cycle while out_valid=1, out_ready=0 -> out_valid=0, out_data=0 next cycle; the following round-robin grant starts at channel 0.
